roulette_round_ctrl: RTL and testbench

ROULETTE_ROUND_CTRL -- requirements
Module: roulette_round_ctrl

---
 rtl/roulette_round_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_roulette_round_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/roulette_round_ctrl.sv
// rtl/roulette_round_ctrl.sv - roulette table round sequencer (bet, spin, settle, clear)
//
// Purpose: collects bets from keyboard key events into numbered bet slots,
// starts the wheel, waits for it to stop (with a cycle timeout), waits for
// the payout processor, then clears the slots for the next round.
// Every output comes straight from a register.
//
// Ports:
//   clock        in   sole clock, rising edge
//   reset        in   asynchronous active-low reset
//   key_valid    in   keyboard byte-latched level; one event per rising edge
//   bet_opcode   in   6'b111110 SPIN, 6'b111111 CANCEL, anything else a bet
//   chip_color   in   chip colour from the sensor, 3'b000 = no chip
//   spin_done    in   wheel stopped, single-cycle pulse
//   payout_ready in   payout computation finished (level)
//   slot_we      out  bet-slot write strobe
//   slot_idx     out  slot being written (0-based), held between writes
//   slot_data    out  {chip_color[1:0], bet_opcode}, held between writes
//   slot_clear   out  clear-all-slots strobe
//   bet_count    out  number of accepted bets
//   spin_req     out  start-wheel pulse
//   spin_active  out  high throughout SPIN and SETTLE
//   round_state  out  00 BET, 01 SPIN, 10 SETTLE, 11 CLEAR
//   err_flags    out  sticky errors: [0] full, [1] timeout, [2] empty spin

module roulette_round_ctrl #(
  parameter int          NUM_SLOTS    = 12,
  parameter logic [31:0] SPIN_TIMEOUT = 32'd100000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       key_valid,
  input  logic [5:0] bet_opcode,
  input  logic [2:0] chip_color,
  input  logic       spin_done,
  input  logic       payout_ready,
  output logic       slot_we,
  output logic [3:0] slot_idx,
  output logic [7:0] slot_data,
  output logic       slot_clear,
  output logic [3:0] bet_count,
  output logic       spin_req,
  output logic       spin_active,
  output logic [1:0] round_state,
  output logic [2:0] err_flags
);

  localparam logic [5:0]  OP_SPIN   = 6'b111110;
  localparam logic [5:0]  OP_CANCEL = 6'b111111;
  localparam logic [3:0]  MAX_SLOTS = 4'(NUM_SLOTS);
  localparam logic [31:0] TIMER_END = SPIN_TIMEOUT - 32'd1;

  typedef enum logic [1:0] {
    ST_BET    = 2'b00,
    ST_SPIN   = 2'b01,
    ST_SETTLE = 2'b10,
    ST_CLEAR  = 2'b11
  } state_t;

  state_t      state_q, state_d;
  logic        key_prev_q;
  logic        key_event;
  logic [3:0]  count_q, count_d;
  logic        we_q, we_d;
  logic [3:0]  idx_q, idx_d;
  logic [7:0]  data_q, data_d;
  logic        clr_q, clr_d;
  logic        spin_req_q, spin_req_d;
  logic        active_q, active_d;
  logic [2:0]  err_q, err_d;
  logic [31:0] timer_q, timer_d;

  // key_prev_q resets to 1 so a key already held at reset release is not an event.
  assign key_event = key_valid & ~key_prev_q;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    we_d    = 1'b0;
    idx_d   = idx_q;
    data_d  = data_q;
    err_d   = err_q;
    timer_d = timer_q;

    case (state_q)
      ST_BET: begin
        if (key_event) begin
          if (bet_opcode == OP_CANCEL) begin
            state_d = ST_CLEAR;
            err_d   = 3'b000;
          end else if (bet_opcode == OP_SPIN) begin
            if (count_q != 4'd0) begin
              state_d = ST_SPIN;
              timer_d = 32'd0;
            end else begin
              err_d[2] = 1'b1;
            end
          end else if (chip_color != 3'b000) begin
            // A key without a chip is silently dropped; only a full table flags.
            if (count_q < MAX_SLOTS) begin
              we_d    = 1'b1;
              idx_d   = count_q;
              data_d  = {chip_color[1:0], bet_opcode};
              count_d = count_q + 4'd1;
            end else begin
              err_d[0] = 1'b1;
            end
          end
        end
      end
      ST_SPIN: begin
        // spin_done takes priority over a timeout in the same cycle.
        if (spin_done) begin
          state_d = ST_SETTLE;
        end else if (timer_q == TIMER_END) begin
          state_d  = ST_SETTLE;
          err_d[1] = 1'b1;
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end
      ST_SETTLE: begin
        if (payout_ready) begin
          state_d = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        state_d = ST_BET;
        count_d = 4'd0;
      end
      default: begin
        state_d = ST_BET;
      end
    endcase

    // Strobes are registered from the next state so they line up with the
    // state they belong to.
    spin_req_d = (state_q == ST_BET) && (state_d == ST_SPIN);
    clr_d      = (state_d == ST_CLEAR);
    active_d   = (state_d == ST_SPIN) || (state_d == ST_SETTLE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_BET;
      key_prev_q <= 1'b1;
      count_q    <= 4'd0;
      we_q       <= 1'b0;
      idx_q      <= 4'd0;
      data_q     <= 8'd0;
      clr_q      <= 1'b0;
      spin_req_q <= 1'b0;
      active_q   <= 1'b0;
      err_q      <= 3'b000;
      timer_q    <= 32'd0;
    end else begin
      state_q    <= state_d;
      key_prev_q <= key_valid;
      count_q    <= count_d;
      we_q       <= we_d;
      idx_q      <= idx_d;
      data_q     <= data_d;
      clr_q      <= clr_d;
      spin_req_q <= spin_req_d;
      active_q   <= active_d;
      err_q      <= err_d;
      timer_q    <= timer_d;
    end
  end

  assign slot_we     = we_q;
  assign slot_idx    = idx_q;
  assign slot_data   = data_q;
  assign slot_clear  = clr_q;
  assign bet_count   = count_q;
  assign spin_req    = spin_req_q;
  assign spin_active = active_q;
  assign round_state = state_q;
  assign err_flags   = err_q;

endmodule

// File: tb/tb_roulette_round_ctrl.sv
// tb/tb_roulette_round_ctrl.sv - directed self-checking bench for roulette_round_ctrl
module tb_roulette_round_ctrl;

  localparam logic [5:0] OP_SPIN   = 6'b111110;
  localparam logic [5:0] OP_CANCEL = 6'b111111;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       key_valid = 1'b0;
  logic [5:0] bet_opcode = 6'd0;
  logic [2:0] chip_color = 3'd0;
  logic       spin_done = 1'b0;
  logic       payout_ready = 1'b0;
  logic       slot_we;
  logic [3:0] slot_idx;
  logic [7:0] slot_data;
  logic       slot_clear;
  logic [3:0] bet_count;
  logic       spin_req;
  logic       spin_active;
  logic [1:0] round_state;
  logic [2:0] err_flags;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int sr_cnt = 0;
  int clr_cnt = 0;
  logic [3:0] wr_idx[$];
  logic [7:0] wr_data[$];

  roulette_round_ctrl #(.NUM_SLOTS(12), .SPIN_TIMEOUT(32'd20)) dut (
    .clock(clock), .reset(reset), .key_valid(key_valid), .bet_opcode(bet_opcode),
    .chip_color(chip_color), .spin_done(spin_done), .payout_ready(payout_ready),
    .slot_we(slot_we), .slot_idx(slot_idx), .slot_data(slot_data),
    .slot_clear(slot_clear), .bet_count(bet_count), .spin_req(spin_req),
    .spin_active(spin_active), .round_state(round_state), .err_flags(err_flags)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (slot_we) begin
      wr_cnt++;
      wr_idx.push_back(slot_idx);
      wr_data.push_back(slot_data);
    end
    if (spin_req) sr_cnt++;
    if (slot_clear) clr_cnt++;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic press(input logic [5:0] op, input logic [2:0] col);
    bet_opcode = op;
    chip_color = col;
    key_valid  = 1'b1;
    tick();
    key_valid  = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #1;
    checks++;
    if ({slot_we, slot_idx, slot_data, slot_clear, bet_count, spin_req, spin_active, round_state, err_flags} !== 25'd0) begin
      errors++;
      $display("FAIL reset_outputs: got we=%b idx=%0d data=%h clr=%b cnt=%0d sreq=%b act=%b st=%0d err=%b, expected all zero",
               slot_we, slot_idx, slot_data, slot_clear, bet_count, spin_req, spin_active, round_state, err_flags);
    end
    tick();
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if (round_state !== 2'b00 || wr_cnt !== 0) begin
      errors++;
      $display("FAIL reset_release: got state=%0d writes=%0d, expected state=0 writes=0", round_state, wr_cnt);
    end
  endtask

  task automatic test_basic_bets();
    int w0 = wr_cnt;
    wr_idx.delete();
    wr_data.delete();
    press(6'd5, 3'b001);
    press(6'd7, 3'b010);
    press(6'd9, 3'b000);
    checks++;
    if (wr_cnt - w0 !== 2) begin
      errors++;
      $display("FAIL basic_write_count: got %0d, expected 2", wr_cnt - w0);
    end
    checks++;
    if (wr_idx.size() != 2 || wr_idx[0] !== 4'd0 || wr_idx[1] !== 4'd1) begin
      errors++;
      $display("FAIL basic_slot_idx: got %p, expected '{0,1}", wr_idx);
    end
    checks++;
    if (wr_data.size() != 2 || wr_data[0] !== 8'h45 || wr_data[1] !== 8'h87) begin
      errors++;
      $display("FAIL basic_slot_data: got %p, expected '{45,87}", wr_data);
    end
    checks++;
    if (bet_count !== 4'd2 || err_flags !== 3'b000 || slot_idx !== 4'd1 || slot_data !== 8'h87) begin
      errors++;
      $display("FAIL basic_state: got cnt=%0d err=%b idx=%0d data=%h, expected cnt=2 err=000 idx=1 data=87",
               bet_count, err_flags, slot_idx, slot_data);
    end
    // Cancel returns through CLEAR to an empty table.
    begin
      int c0 = clr_cnt;
      press(OP_CANCEL, 3'b000);
      checks++;
      if (clr_cnt - c0 !== 1 || bet_count !== 4'd0 || round_state !== 2'b00) begin
        errors++;
        $display("FAIL cancel_clear: got clears=%0d cnt=%0d st=%0d, expected clears=1 cnt=0 st=0",
                 clr_cnt - c0, bet_count, round_state);
      end
    end
  endtask

  task automatic test_held_key();
    int w0 = wr_cnt;
    bet_opcode = 6'd3;
    chip_color = 3'b001;
    key_valid  = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    key_valid = 1'b0;
    tick();
    checks++;
    if (wr_cnt - w0 !== 1 || bet_count !== 4'd1) begin
      errors++;
      $display("FAIL held_key: got writes=%0d cnt=%0d, expected writes=1 cnt=1", wr_cnt - w0, bet_count);
    end
    press(OP_CANCEL, 3'b000);
  endtask

  task automatic test_full_round();
    int w0 = wr_cnt;
    int s0 = sr_cnt;
    int c0 = clr_cnt;
    wr_idx.delete();
    wr_data.delete();
    for (int i = 0; i < 13; i++) press(6'(i + 1), 3'b011);
    checks++;
    if (wr_cnt - w0 !== 12 || bet_count !== 4'd12 || err_flags !== 3'b001) begin
      errors++;
      $display("FAIL full_bets: got writes=%0d cnt=%0d err=%b, expected writes=12 cnt=12 err=001",
               wr_cnt - w0, bet_count, err_flags);
    end
    checks++;
    if (wr_idx.size() != 12 || wr_idx[11] !== 4'd11 || wr_data[11] !== 8'hCC) begin
      errors++;
      $display("FAIL full_last_slot: got n=%0d idx=%0d data=%h, expected n=12 idx=11 data=cc",
               wr_idx.size(), wr_idx[11], wr_data[11]);
    end
    press(OP_SPIN, 3'b000);
    checks++;
    if (round_state !== 2'b01 || sr_cnt - s0 !== 1 || spin_active !== 1'b1 || spin_req !== 1'b0) begin
      errors++;
      $display("FAIL full_spin: got st=%0d spin_reqs=%0d act=%b sreq=%b, expected st=1 spin_reqs=1 act=1 sreq=0",
               round_state, sr_cnt - s0, spin_active, spin_req);
    end
    spin_done = 1'b1;
    tick();
    spin_done = 1'b0;
    checks++;
    if (round_state !== 2'b10 || spin_active !== 1'b1) begin
      errors++;
      $display("FAIL full_settle: got st=%0d act=%b, expected st=2 act=1", round_state, spin_active);
    end
    payout_ready = 1'b1;
    tick();
    payout_ready = 1'b0;
    checks++;
    if (round_state !== 2'b11 || slot_clear !== 1'b1 || spin_active !== 1'b0) begin
      errors++;
      $display("FAIL full_clear: got st=%0d clr=%b act=%b, expected st=3 clr=1 act=0", round_state, slot_clear, spin_active);
    end
    tick();
    checks++;
    if (round_state !== 2'b00 || bet_count !== 4'd0 || slot_clear !== 1'b0 || clr_cnt - c0 !== 1 || err_flags !== 3'b001) begin
      errors++;
      $display("FAIL full_back_to_bet: got st=%0d cnt=%0d clr=%b clears=%0d err=%b, expected st=0 cnt=0 clr=0 clears=1 err=001",
               round_state, bet_count, slot_clear, clr_cnt - c0, err_flags);
    end
  endtask

  task automatic test_empty_spin();
    int s0 = sr_cnt;
    press(OP_SPIN, 3'b000);
    checks++;
    if (round_state !== 2'b00 || err_flags !== 3'b101 || sr_cnt - s0 !== 0) begin
      errors++;
      $display("FAIL empty_spin: got st=%0d err=%b spin_reqs=%0d, expected st=0 err=101 spin_reqs=0",
               round_state, err_flags, sr_cnt - s0);
    end
    press(OP_CANCEL, 3'b000);
    checks++;
    if (err_flags !== 3'b000 || round_state !== 2'b00) begin
      errors++;
      $display("FAIL cancel_clears_flags: got err=%b st=%0d, expected err=000 st=0", err_flags, round_state);
    end
  endtask

  task automatic test_timeout();
    int n = 0;
    press(6'd2, 3'b100);
    bet_opcode = OP_SPIN;
    key_valid  = 1'b1;
    tick();
    key_valid  = 1'b0;
    checks++;
    if (spin_req !== 1'b1) begin
      errors++;
      $display("FAIL timeout_spin_req: got %b, expected 1", spin_req);
    end
    while (round_state !== 2'b10 && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (n !== 20 || err_flags !== 3'b010) begin
      errors++;
      $display("FAIL timeout_exit: got cycles=%0d err=%b, expected cycles=20 err=010", n, err_flags);
    end
    payout_ready = 1'b1;
    tick();
    payout_ready = 1'b0;
    tick();
    press(OP_CANCEL, 3'b000);

    // spin_done in the same cycle the timer expires: spin_done wins.
    press(6'd2, 3'b100);
    bet_opcode = OP_SPIN;
    key_valid  = 1'b1;
    tick();
    key_valid  = 1'b0;
    for (int i = 0; i < 19; i++) tick();
    checks++;
    if (round_state !== 2'b01) begin
      errors++;
      $display("FAIL timeout_still_spinning: got st=%0d, expected st=1", round_state);
    end
    spin_done = 1'b1;
    tick();
    spin_done = 1'b0;
    checks++;
    if (round_state !== 2'b10 || err_flags !== 3'b000) begin
      errors++;
      $display("FAIL done_beats_timeout: got st=%0d err=%b, expected st=2 err=000", round_state, err_flags);
    end
    // A stray spin_done in SETTLE changes nothing.
    spin_done = 1'b1;
    tick();
    spin_done = 1'b0;
    tick();
    checks++;
    if (round_state !== 2'b10 || err_flags !== 3'b000) begin
      errors++;
      $display("FAIL stray_spin_done: got st=%0d err=%b, expected st=2 err=000", round_state, err_flags);
    end
    payout_ready = 1'b1;
    tick();
    payout_ready = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_spin();
    int w0, s0, c0;
    press(6'd4, 3'b001);
    press(OP_SPIN, 3'b000);
    tick();
    tick();
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({slot_we, slot_idx, slot_data, slot_clear, bet_count, spin_req, spin_active, round_state, err_flags} !== 25'd0) begin
      errors++;
      $display("FAIL reset_mid_spin_async: got we=%b idx=%0d data=%h clr=%b cnt=%0d sreq=%b act=%b st=%0d err=%b, expected all zero",
               slot_we, slot_idx, slot_data, slot_clear, bet_count, spin_req, spin_active, round_state, err_flags);
    end
    // Key held high across release must not produce an event.
    bet_opcode = 6'd8;
    chip_color = 3'b010;
    key_valid  = 1'b1;
    tick();
    tick();
    w0 = wr_cnt;
    s0 = sr_cnt;
    c0 = clr_cnt;
    reset = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    key_valid = 1'b0;
    tick();
    checks++;
    if (wr_cnt - w0 !== 0 || sr_cnt - s0 !== 0 || clr_cnt - c0 !== 0 || round_state !== 2'b00 || bet_count !== 4'd0) begin
      errors++;
      $display("FAIL reset_release_quiet: got writes=%0d spin_reqs=%0d clears=%0d st=%0d cnt=%0d, expected all zero",
               wr_cnt - w0, sr_cnt - s0, clr_cnt - c0, round_state, bet_count);
    end
  endtask

  initial begin
    test_reset();
    test_basic_bets();
    test_held_key();
    test_full_round();
    test_empty_spin();
    test_timeout();
    test_reset_mid_spin();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
